// File: rtl/enc_sym_gearbox.sv
// rtl/enc_sym_gearbox.sv - symbol realignment buffer between the RS encoder and the output stage
module enc_sym_gearbox #(
    parameter int EGF_ORDER  = 8,
    parameter int IN_SYM     = 4,
    parameter int OUT_SYM    = 4,
    parameter int DEPTH      = 8,
    parameter int RS_MES_LEN = 239
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [$clog2(IN_SYM+1)-1:0]         in_count,
    input  logic [IN_SYM-1:0][EGF_ORDER-1:0]    in_data,
    input  logic [$clog2(OUT_SYM+1)-1:0]        out_req,
    output logic                                out_valid,
    output logic [OUT_SYM-1:0][EGF_ORDER-1:0]   out_data,
    output logic                                out_last,
    output logic [$clog2(DEPTH+1)-1:0]          level,
    output logic                                err
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int MES_W = $clog2(RS_MES_LEN);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SEL_W = (IN_SYM > 1) ? $clog2(IN_SYM) : 1;

    logic [EGF_ORDER-1:0] store     [DEPTH];
    logic [EGF_ORDER-1:0] store_nxt [DEPTH];
    logic [LVL_W-1:0]     level_q;
    logic [MES_W-1:0]     mes_cnt;
    logic                 err_q;
    logic                 bad_req;
    logic                 bad_beat;
    int                   eff_req;
    int                   pop_n;
    int                   push_n;
    int                   surv;

    assign level = level_q;
    assign err   = err_q;

    // Handshake decisions use only registered state, never the same-cycle push.
    always_comb begin
        bad_req = int'(out_req) > OUT_SYM;
        eff_req = bad_req ? 0 : int'(out_req);
        if (eff_req > RS_MES_LEN - int'(mes_cnt)) begin
            eff_req = RS_MES_LEN - int'(mes_cnt);
        end
        out_valid = !flush && (eff_req != 0) && (int'(level_q) >= eff_req);
        pop_n     = out_valid ? eff_req : 0;
        out_last  = out_valid && (int'(mes_cnt) + eff_req == RS_MES_LEN);
        in_ready  = (DEPTH - int'(level_q) >= IN_SYM) && !flush;
        bad_beat  = in_valid && in_ready && ((in_count == '0) || (int'(in_count) > IN_SYM));
        push_n    = (in_valid && in_ready && !bad_beat) ? int'(in_count) : 0;
        surv      = int'(level_q) - pop_n;
    end

    // Survivors shift down by pop_n; the new beat lands right behind them.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            store_nxt[j] = '0;
            if (j < surv) begin
                store_nxt[j] = store[IDX_W'(j + pop_n)];
            end else if (j - surv < push_n) begin
                store_nxt[j] = in_data[SEL_W'(j - surv)];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < OUT_SYM; i++) begin
            out_data[i] = (out_valid && (i < eff_req)) ? store[IDX_W'(i)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                store[j] <= '0;
            end
            level_q <= '0;
            mes_cnt <= '0;
            err_q   <= 1'b0;
        end else if (flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                store[j] <= '0;
            end
            level_q <= '0;
            mes_cnt <= '0;
            err_q   <= err_q | bad_req;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                store[j] <= store_nxt[j];
            end
            level_q <= LVL_W'(surv + push_n);
            mes_cnt <= out_last ? '0 : MES_W'(int'(mes_cnt) + pop_n);
            err_q   <= err_q | bad_req | bad_beat;
        end
    end
endmodule
